jalr_resolve_ctrl: RTL and testbench

Sequences retirement of JALR instructions held in the JALR queue. When the ROB head is a JALR, it waits for the queue head's target to resolve, then compares it against the predicted target. It dequeues the entry and acknowledges commit to the ROB. On a target mismatch it issues a front-end redirect and a multi-cycle pipeline flush, and keeps mispredict statistics.

---
 rtl/jalr_resolve_ctrl.sv | 101 ++++++++++
 tb/tb_jalr_resolve_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/jalr_resolve_ctrl.sv
// JALR retirement sequencer: waits for the queue head target, compares it with the
// prediction, dequeues/acks the ROB and redirects + flushes the front end on a mismatch.
module jalr_resolve_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rob_head_jalr,
    input  logic             head_ready,
    input  logic [31:0]      jalr_actual_address,
    input  logic [31:0]      jalr_taken_address,
    output logic             rd_en,
    output logic             commit_ack,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic             busy,
    output logic [CNT_W-1:0] jalr_count,
    output logic [CNT_W-1:0] mispredict_count
);
    localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, CHECK, RESOLVE, FLUSH} state_t;

    state_t            state, state_next;
    logic [31:0]       target, pred;
    logic [FC_W-1:0]   flush_cnt;
    logic [31:0]       masked_actual;
    logic              mismatch;

    assign masked_actual = jalr_actual_address & 32'hFFFF_FFFE;
    assign mismatch      = (target != pred);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            target           <= '0;
            pred             <= '0;
            redirect_pc      <= '0;
            flush_cnt        <= '0;
            jalr_count       <= '0;
            mispredict_count <= '0;
        end else begin
            state <= state_next;
            // redirect_pc is loaded one edge early so it is registered in the RESOLVE cycle
            if (state == CHECK && rob_head_jalr && head_ready) begin
                target <= masked_actual;
                pred   <= jalr_taken_address;
                if (masked_actual != jalr_taken_address)
                    redirect_pc <= masked_actual;
            end
            if (state == RESOLVE) begin
                if (jalr_count != '1)
                    jalr_count <= jalr_count + 1'b1;
                if (mismatch) begin
                    if (mispredict_count != '1)
                        mispredict_count <= mispredict_count + 1'b1;
                    flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
                end
            end else if (state == FLUSH) begin
                flush_cnt <= flush_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (rob_head_jalr) state_next = CHECK;
            CHECK: begin
                if (!rob_head_jalr)  state_next = IDLE;
                else if (head_ready) state_next = RESOLVE;
            end
            RESOLVE: begin
                if (mismatch && FLUSH_CYCLES > 1) state_next = FLUSH;
                else                              state_next = IDLE;
            end
            FLUSH:   if (flush_cnt == FC_W'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_en          = 1'b0;
        commit_ack     = 1'b0;
        redirect_valid = 1'b0;
        flush          = 1'b0;
        busy           = (state != IDLE);
        case (state)
            RESOLVE: begin
                rd_en          = 1'b1;
                commit_ack     = 1'b1;
                redirect_valid = mismatch;
                flush          = mismatch;
            end
            FLUSH:   flush = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_jalr_resolve_ctrl.sv
// Directed + randomized bench for jalr_resolve_ctrl; a 2-bit-counter instance covers saturation.
module tb_jalr_resolve_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        rob_head_jalr, head_ready;
    logic [31:0] act, tak;

    logic        rd_en, commit_ack, redirect_valid, flush, busy;
    logic [31:0] redirect_pc;
    logic [15:0] jalr_count, mispredict_count;

    logic        s_rd, s_ack, s_rv, s_flush, s_busy;
    logic [31:0] s_pc;
    logic [1:0]  s_jc, s_mc;

    int checks = 0, failures = 0;
    int jcnt = 0, mcnt = 0;
    int cyc = 0, rd_pulses = 0;
    int ack_cycles[$];

    always #5 clk = ~clk;

    jalr_resolve_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .rob_head_jalr(rob_head_jalr), .head_ready(head_ready),
        .jalr_actual_address(act), .jalr_taken_address(tak),
        .rd_en(rd_en), .commit_ack(commit_ack), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush(flush), .busy(busy),
        .jalr_count(jalr_count), .mispredict_count(mispredict_count));

    jalr_resolve_ctrl #(.FLUSH_CYCLES(2), .CNT_W(2)) u_sat (
        .clk(clk), .reset_n(reset_n), .rob_head_jalr(rob_head_jalr), .head_ready(head_ready),
        .jalr_actual_address(act), .jalr_taken_address(tak),
        .rd_en(s_rd), .commit_ack(s_ack), .redirect_valid(s_rv),
        .redirect_pc(s_pc), .flush(s_flush), .busy(s_busy),
        .jalr_count(s_jc), .mispredict_count(s_mc));

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) rd_pulses <= rd_pulses + 1;
        if (commit_ack) ack_cycles.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_jcnt"}, 32'(jalr_count), 32'(sat(jcnt, 65535)));
        chk({tag, "_mcnt"}, 32'(mispredict_count), 32'(sat(mcnt, 65535)));
        chk({tag, "_sat_jcnt"}, 32'(s_jc), 32'(sat(jcnt, 3)));
        chk({tag, "_sat_mcnt"}, 32'(s_mc), 32'(sat(mcnt, 3)));
    endtask

    // Outputs that must be quiet outside the resolve cycle
    task automatic chk_quiet(input string tag, input logic exp_busy, input logic exp_flush);
        chk({tag, "_rd"}, 32'(rd_en), 32'(0));
        chk({tag, "_ack"}, 32'(commit_ack), 32'(0));
        chk({tag, "_rv"}, 32'(redirect_valid), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(exp_busy));
        chk({tag, "_flush"}, 32'(flush), 32'(exp_flush));
        chk({tag, "_sat_rd"}, 32'(s_rd), 32'(0));
    endtask

    // One JALR: raise request, wait w cycles unresolved, resolve, then follow the flush if any.
    task automatic run_jalr(input logic [31:0] a, input logic [31:0] t, input int w, input bit b2b);
        logic        mis;
        logic [31:0] tgt;
        tgt = a & 32'hFFFF_FFFE;
        mis = (tgt != t);
        rob_head_jalr = 1'b1;
        head_ready    = 1'b0;
        step();
        chk_quiet("check", 1'b1, 1'b0);
        for (int i = 0; i < w; i++) begin
            step();
            chk_quiet("wait", 1'b1, 1'b0);
        end
        head_ready = 1'b1;
        act = a;
        tak = t;
        step();
        chk("res_rd", 32'(rd_en), 32'(1));
        chk("res_ack", 32'(commit_ack), 32'(1));
        chk("res_rv", 32'(redirect_valid), 32'(mis));
        chk("res_flush", 32'(flush), 32'(mis));
        chk("res_busy", 32'(busy), 32'(1));
        chk("res_sat_ack", 32'(s_ack), 32'(1));
        if (mis) chk("res_pc", redirect_pc, tgt);
        chk_cnt("res_before");
        head_ready    = 1'b0;
        act           = $urandom;
        rob_head_jalr = b2b && !mis;
        jcnt++;
        if (mis) mcnt++;
        step();
        chk_cnt("res_after");
        if (mis) begin
            chk_quiet("flush2", 1'b1, 1'b1);
            step();
            chk_quiet("flush_done", 1'b0, 1'b0);
            chk("pc_hold", redirect_pc, tgt);
        end else begin
            chk_quiet("post_ok", 1'b0, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, n0;
        logic [31:0] a, t;
        reset_n = 1'b0;
        rob_head_jalr = 1'b0;
        head_ready = 1'b0;
        act = '0;
        tak = '0;
        #12;
        chk_quiet("reset", 1'b0, 1'b0);
        chk("reset_pc", redirect_pc, 32'h0);
        chk_cnt("reset");
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk_quiet("idle", 1'b0, 1'b0);

        // correct prediction: bit 0 of the actual target is masked away
        run_jalr(32'h0000_1005, 32'h0000_1004, 3, 1'b0);
        // mispredict with a two-cycle flush
        run_jalr(32'h0000_2000, 32'h0000_1000, 0, 1'b0);
        // predicted target with bit 0 set can never match
        run_jalr(32'h0000_3001, 32'h0000_3001, 1, 1'b0);

        // squash while waiting for the operand
        p0 = rd_pulses;
        rob_head_jalr = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            chk_quiet("squash_wait", 1'b1, 1'b0);
        end
        rob_head_jalr = 1'b0;
        step();
        chk_quiet("squash_idle", 1'b0, 1'b0);
        chk_cnt("squash");
        chk("squash_rd_pulses", 32'(rd_pulses), 32'(p0));

        // back-to-back correct JALRs: acks three cycles apart, two dequeues
        @(negedge clk);
        p0 = rd_pulses;
        n0 = ack_cycles.size();
        run_jalr(32'h0000_4000, 32'h0000_4000, 0, 1'b1);
        run_jalr(32'h0000_5000, 32'h0000_5000, 0, 1'b0);
        @(negedge clk);
        chk("b2b_rd_pulses", 32'(rd_pulses - p0), 32'(2));
        chk("b2b_acks", 32'(ack_cycles.size() - n0), 32'(2));
        if (ack_cycles.size() >= n0 + 2)
            chk("b2b_spacing", 32'(ack_cycles[n0 + 1] - ack_cycles[n0]), 32'(3));

        // randomized JALRs and squashes
        for (int k = 0; k < 40; k++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0, 1: t = a & 32'hFFFF_FFFE;
                2:    t = a | 32'h1;
                default: t = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) begin
                rob_head_jalr = 1'b1;
                head_ready = 1'b0;
                step();
                rob_head_jalr = 1'b0;
                step();
                chk_quiet("rnd_squash", 1'b0, 1'b0);
                chk_cnt("rnd_squash");
            end else begin
                run_jalr(a, t, $urandom_range(0, 3), 1'b0);
            end
        end

        // asynchronous reset in the second flush cycle
        rob_head_jalr = 1'b1;
        step();
        head_ready = 1'b1;
        act = 32'h0000_6000;
        tak = 32'h0000_7000;
        step();
        chk("ar_res_flush", 32'(flush), 32'(1));
        rob_head_jalr = 1'b0;
        head_ready = 1'b0;
        step();
        chk("ar_flush2", 32'(flush), 32'(1));
        #2;
        reset_n = 1'b0;
        #1;
        jcnt = 0;
        mcnt = 0;
        chk_quiet("ar_reset", 1'b0, 1'b0);
        chk("ar_pc", redirect_pc, 32'h0);
        chk_cnt("ar_reset");
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk_quiet("ar_idle", 1'b0, 1'b0);
        step();
        chk_quiet("ar_idle2", 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
